// File: rtl/osd_value_bcd.sv
// osd_value_bcd: holds a signed measurement and converts it once per frame
// into a sign flag and four BCD digits for the on-screen digit window.
//
// The conversion uses a serial shift-add-3 (double-dabble) engine. It starts
// at a frame_sync strobe when a captured value is pending. The output
// registers update together in a single LOAD cycle, so the digit window
// never shows a partially converted number.
//
// Ports:
//   clk          pixel clock, shared with the digit window stage
//   rst_n        asynchronous active-low reset
//   value        signed two's-complement measurement (W bits)
//   value_valid  single-cycle strobe that captures value
//   frame_sync   single-cycle strobe at the start of vertical blanking
//   znak         displayed sign, 1 = negative
//   cifra_XXXX   thousands digit; cifra_XXX hundreds; cifra_XX tens;
//   cifra_X      units digit (all BCD)
//   ovf          displayed magnitude was saturated to MAXV
//   busy         conversion in progress
module osd_value_bcd #(
  parameter int unsigned W    = 16,
  parameter int unsigned MAXV = 9999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] value,
  input  logic         value_valid,
  input  logic         frame_sync,
  output logic         znak,
  output logic [3:0]   cifra_XXXX,
  output logic [3:0]   cifra_XXX,
  output logic [3:0]   cifra_XX,
  output logic [3:0]   cifra_X,
  output logic         ovf,
  output logic         busy
);

  localparam logic [W:0]  MaxvWide = (W+1)'(MAXV);
  localparam logic [13:0] MaxvMag  = 14'(MAXV);

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          pending_q, pending_d;
  logic          sign_q, sign_d;
  logic          ovf_w_q, ovf_w_d;
  logic [13:0]   mag_q, mag_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          znak_q, znak_d;
  logic [15:0]   dig_q, dig_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic [W:0]    ext;
  logic [W:0]    mag_full;
  logic [15:0]   bcd_adj;
  logic          start;

  // Sign-extend by one bit so that the most negative input does not wrap.
  always_comb begin
    ext      = {hold_q[W-1], hold_q};
    mag_full = hold_q[W-1] ? (~ext + 1'b1) : ext;
  end

  // Add-3 correction on every nibble that would overflow past 9 after shifting.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign start = (state_q == StIdle) && frame_sync && pending_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    sign_d    = sign_q;
    ovf_w_d   = ovf_w_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    znak_d    = znak_q;
    dig_d     = dig_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;

    // A start clears pending, but a capture on the same edge re-arms it.
    if (start) begin
      pending_d = 1'b0;
    end
    if (value_valid) begin
      hold_d    = value;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StConv;
          sign_d  = hold_q[W-1];
          if (mag_full > MaxvWide) begin
            mag_d   = MaxvMag;
            ovf_w_d = 1'b1;
          end else begin
            mag_d   = mag_full[13:0];
            ovf_w_d = 1'b0;
          end
          bcd_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      StConv: begin
        bcd_d = {bcd_adj[14:0], mag_q[13]};
        mag_d = {mag_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        dig_d   = bcd_q;
        znak_d  = sign_q & (bcd_q != 16'd0);
        ovf_d   = ovf_w_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      pending_q <= 1'b0;
      sign_q    <= 1'b0;
      ovf_w_q   <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      znak_q    <= 1'b0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      sign_q    <= sign_d;
      ovf_w_q   <= ovf_w_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      znak_q    <= znak_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign znak       = znak_q;
  assign cifra_XXXX = dig_q[15:12];
  assign cifra_XXX  = dig_q[11:8];
  assign cifra_XX   = dig_q[7:4];
  assign cifra_X    = dig_q[3:0];
  assign ovf        = ovf_q;
  assign busy       = busy_q;

endmodule
